// File: rtl/fxp_float_pkg.sv
// Shared constants and FSM state type for the fixed-point to IEEE-754 single converter.
package fxp_float_pkg;
  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;

  typedef enum logic [1:0] {IDLE, NORM, PACK, OUT} state_e;
endpackage

// File: rtl/fxp_float_pack.sv
// Combinational packing of a normalized magnitude into an FP32 word: mantissa alignment,
// optional half-up rounding with carry into the exponent, and zero handling. No storage.
module fxp_float_pack
  import fxp_float_pkg::*;
#(
  parameter int W     = 16,
  parameter bit ROUND = 1'b1
) (
  input  logic                  sign_i,
  input  logic [FP32_EXP_W-1:0] exp_i,
  input  logic [W-1:0]          mag_i,
  output logic [31:0]           word_o
);
  // Fraction bits below the hidden one, padded with enough zeros that the round bit always
  // exists: it lands on a pad zero whenever the fraction already fits in 23 bits.
  localparam int EW = W + FP32_MANT_W;

  logic [EW-1:0]            ext;
  logic [FP32_MANT_W-1:0]   frac_trunc;
  logic                     rnd_bit;
  logic [FP32_MANT_W:0]     frac_sum;
  logic [FP32_EXP_W-1:0]    exp_adj;
  logic                     unused_low;

  assign ext        = {mag_i[W-2:0], {(FP32_MANT_W+1){1'b0}}};
  assign frac_trunc = ext[EW-1 -: FP32_MANT_W];
  assign rnd_bit    = ROUND ? ext[W-1] : 1'b0;
  assign frac_sum   = {1'b0, frac_trunc} + {{FP32_MANT_W{1'b0}}, rnd_bit};
  // On carry the low 23 bits of frac_sum are already zero.
  assign exp_adj    = exp_i + {{(FP32_EXP_W-1){1'b0}}, frac_sum[FP32_MANT_W]};
  assign unused_low = ^ext[W-2:0];

  always_comb begin
    word_o = 32'h0000_0000;
    if (mag_i != '0) begin
      word_o = {sign_i, exp_adj, frac_sum[FP32_MANT_W-1:0]};
    end
  end
endmodule

// File: rtl/fxp_to_float_seq.sv
// Signed fixed-point to FP32 converter, one normalization shift per cycle; latency n+2.
// One word in flight: i_ready low from accept until o_valid/o_ready handshake; o_data held.
module fxp_to_float_seq
  import fxp_float_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter bit ROUND = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WII+WIF-1:0]   i_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [31:0]          o_data,
  output logic                 o_valid,
  input  logic                 o_ready
);
  localparam int W = WII + WIF;
  localparam logic [FP32_EXP_W-1:0] EXP_INIT = FP32_EXP_W'(FP32_BIAS + W - 1 - WIF);

  state_e                  state_q, state_d;
  logic [W-1:0]            mag_q, mag_d;
  logic [FP32_EXP_W-1:0]   exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [31:0]             out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             pack_word;

  fxp_float_pack #(.W(W), .ROUND(ROUND)) u_pack (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .mag_i  (mag_q),
    .word_o (pack_word)
  );

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          sign_d  = i_data[W-1];
          // Negating the most negative word wraps to 2^(W-1), the correct unsigned magnitude.
          mag_d   = i_data[W-1] ? -i_data : i_data;
          exp_d   = EXP_INIT;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0 || mag_q[W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      PACK: begin
        out_data_d  = pack_word;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (o_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_data  = out_data_q;
  assign o_valid = out_valid_q;
endmodule

// File: tb/tb_fxp_to_float_seq.sv
// Bench for fxp_to_float_seq: three configurations (8.8 round, 16.16 round, 16.16 truncate)
// checked against a value-level float model, plus literal expectations from hand calculation.
module tb_fxp_to_float_seq;
  localparam int WII_T [3] = '{8, 16, 16};
  localparam int WIF_T [3] = '{8, 16, 16};
  localparam bit RND_T [3] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] din2 = '0;
  logic        vld  [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ovld [3];
  logic [31:0] dout [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_dat [3][$];
  int          exp_lat [3][$];
  int          acc_cyc [3];
  bit          busy    [3];
  bit          seen    [3];
  logic [31:0] prev_dat[3];
  logic [31:0] last_out[3];
  int          last_lat[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fxp_to_float_seq #(.WII(8), .WIF(8), .ROUND(1'b1)) u_q8 (
    .clk(clk), .rst(rst), .i_data(din0), .i_valid(vld[0]), .i_ready(irdy[0]),
    .o_data(dout[0]), .o_valid(ovld[0]), .o_ready(ordy[0]));
  fxp_to_float_seq #(.WII(16), .WIF(16), .ROUND(1'b1)) u_q16r (
    .clk(clk), .rst(rst), .i_data(din1), .i_valid(vld[1]), .i_ready(irdy[1]),
    .o_data(dout[1]), .o_valid(ovld[1]), .o_ready(ordy[1]));
  fxp_to_float_seq #(.WII(16), .WIF(16), .ROUND(1'b0)) u_q16t (
    .clk(clk), .rst(rst), .i_data(din2), .i_valid(vld[2]), .i_ready(irdy[2]),
    .o_data(dout[2]), .o_valid(ovld[2]), .o_ready(ordy[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] get_din(input int d);
    case (d)
      0:       return {16'h0000, din0};
      1:       return din1;
      default: return din2;
    endcase
  endfunction

  task automatic set_din(input int d, input logic [31:0] v);
    case (d)
      0:       din0 = v[15:0];
      1:       din1 = v;
      default: din2 = v;
    endcase
  endtask

  // Signed value of the raw word, as a plain integer.
  function automatic longint sval(input int d, input logic [31:0] raw);
    int     w = WII_T[d] + WIF_T[d];
    longint v = longint'({32'h0, raw});
    if (raw[w-1]) v = v - (64'sd1 <<< w);
    return v;
  endfunction

  function automatic int msb_of(input longint m);
    int p = 0;
    for (int i = 0; i < 63; i++) if (((m >>> i) & 64'sd1) != 0) p = i;
    return p;
  endfunction

  // value = m * 2^-WIF with m = 1.f * 2^p, so exponent = p - WIF.
  function automatic logic [31:0] fp_model(input int d, input logic [31:0] raw);
    longint v = sval(d, raw);
    longint m = (v < 0) ? -v : v;
    longint rem, mant;
    int     p, e;
    logic [7:0] e8;
    if (m == 0) return 32'h0000_0000;
    p    = msb_of(m);
    e    = 127 + p - WIF_T[d];
    rem  = m - (64'sd1 <<< p);
    if (p <= 23) begin
      mant = rem <<< (23 - p);
    end else begin
      mant = rem >>> (p - 23);
      if (RND_T[d] && (((rem >>> (p - 24)) & 64'sd1) != 0)) mant = mant + 1;
      if (mant == (64'sd1 <<< 23)) begin
        mant = 0;
        e    = e + 1;
      end
    end
    e8 = e[7:0];
    return {(v < 0), e8, mant[22:0]};
  endfunction

  function automatic int lat_model(input int d, input logic [31:0] raw);
    longint v = sval(d, raw);
    longint m = (v < 0) ? -v : v;
    if (m == 0) return 2;
    return (WII_T[d] + WIF_T[d] - 1 - msb_of(m)) + 2;
  endfunction

  // Compare process: every falling edge, every instance.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        exp_dat[d].delete();
        exp_lat[d].delete();
        busy[d] = 1'b0;
        seen[d] = 1'b0;
        chk($sformatf("rst_o_valid_dut%0d", d), ovld[d], 64'd0);
        chk($sformatf("rst_i_ready_dut%0d", d), irdy[d], 64'd1);
        chk($sformatf("rst_o_data_dut%0d", d), dout[d], 64'd0);
      end else begin
        chk($sformatf("i_ready_dut%0d", d), irdy[d], !busy[d]);
        if (ovld[d]) begin
          if (exp_dat[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_o_valid_dut%0d: got o_valid=1 o_data=%08h, required no output", d, dout[d]);
          end else if (!seen[d]) begin
            chk($sformatf("o_data_dut%0d", d), dout[d], exp_dat[d][0]);
            chk($sformatf("latency_dut%0d", d), cyc - acc_cyc[d], exp_lat[d][0]);
            seen[d]     = 1'b1;
            prev_dat[d] = dout[d];
            last_out[d] = dout[d];
            last_lat[d] = cyc - acc_cyc[d];
          end else begin
            chk($sformatf("o_data_hold_dut%0d", d), dout[d], prev_dat[d]);
          end
          if (ordy[d] && exp_dat[d].size() != 0) begin
            void'(exp_dat[d].pop_front());
            void'(exp_lat[d].pop_front());
            busy[d] = 1'b0;
            seen[d] = 1'b0;
          end
        end
        if (vld[d] && irdy[d]) begin
          exp_dat[d].push_back(fp_model(d, get_din(d)));
          exp_lat[d].push_back(lat_model(d, get_din(d)));
          acc_cyc[d] = cyc + 1;
          busy[d]    = 1'b1;
        end
      end
    end
  end

  task automatic send(input int d, input logic [31:0] v);
    bit ok = 1'b0;
    @(posedge clk); #2;
    set_din(d, v);
    vld[d] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (irdy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    vld[d] = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout_dut%0d: got i_ready=0 for 100 cycles, required acceptance", d);
    end
  endtask

  task automatic wait_done(input int d);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #3;
      if (!busy[d] && exp_dat[d].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout_dut%0d: got no output handshake in 300 cycles, required completion", d);
    end
  endtask

  task automatic run(input string nm, input int d, input logic [31:0] v,
                     input logic [31:0] lit, input int lit_lat);
    send(d, v);
    wait_done(d);
    chk({nm, "_lit"}, last_out[d], lit);
    chk({nm, "_lat_lit"}, last_lat[d], lit_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int d = 0; d < 3; d++) begin
      vld[d]  = 1'b0;
      ordy[d] = 1'b1;
    end

    // Model pins against hand arithmetic.
    chk("model_pin_one",   fp_model(0, 32'h0000_0100), 64'h3F80_0000);
    chk("model_pin_carry", fp_model(1, 32'h01FF_FFFF), 64'h4400_0000);
    chk("model_pin_trunc", fp_model(2, 32'h0100_0001), 64'h4380_0000);
    chk("model_pin_lat",   lat_model(0, 32'h0000_0001), 64'd17);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_i_ready_dut%0d", d), irdy[d], 64'd1);
      chk($sformatf("post_rst_o_valid_dut%0d", d), ovld[d], 64'd0);
      chk($sformatf("post_rst_o_data_dut%0d", d), dout[d], 64'd0);
    end

    run("q8_pos_one",      0, 32'h0000_0100, 32'h3F80_0000, 9);
    run("q8_neg_one",      0, 32'h0000_FF00, 32'hBF80_0000, 9);
    run("q8_zero",         0, 32'h0000_0000, 32'h0000_0000, 2);
    run("q8_most_neg",     0, 32'h0000_8000, 32'hC300_0000, 2);
    run("q8_lsb",          0, 32'h0000_0001, 32'h3B80_0000, 17);
    run("q8_max_pos",      0, 32'h0000_7FFF, 32'h42FF_FE00, 3);
    run("q16r_round",      1, 32'h0100_0001, 32'h4380_0001, 9);
    run("q16t_trunc",      2, 32'h0100_0001, 32'h4380_0000, 9);
    run("q16r_carry",      1, 32'h01FF_FFFF, 32'h4400_0000, 9);
    run("q16t_nocarry",    2, 32'h01FF_FFFF, 32'h43FF_FFFF, 9);
    run("q16r_neg_round",  1, 32'hFEFF_FFFF, 32'hC380_0001, 9);
    run("q16r_most_neg",   1, 32'h8000_0000, 32'hC700_0000, 2);
    run("q16t_neg_one",    2, 32'hFFFF_0000, 32'hBF80_0000, 17);

    // Backpressure: hold o_ready low for 5 cycles while a second word is offered.
    @(posedge clk); #2 ordy[0] = 1'b0;
    send(0, 32'h0000_0300);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (ovld[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("stall_o_valid_seen", ok, 64'd1);
    set_din(0, 32'h0000_0500);
    vld[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("stall_i_ready_low", irdy[0], 64'd0);
      chk("stall_o_data",      dout[0], 64'h4040_0000);
    end
    vld[0]  = 1'b0;
    ordy[0] = 1'b1;
    wait_done(0);
    chk("stall_result_lit", last_out[0], 64'h4040_0000);
    repeat (5) @(posedge clk);
    #2 chk("stall_no_second_accept", irdy[0], 64'd1);

    // Reset while normalizing: the word is dropped and nothing comes out afterwards.
    send(0, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", ovld[0], 64'd0);
    chk("mid_rst_i_ready", irdy[0], 64'd1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("after_rst_i_ready", irdy[0], 64'd1);
    chk("after_rst_o_valid", ovld[0], 64'd0);
    repeat (25) @(posedge clk);
    run("q8_after_rst",    0, 32'h0000_0100, 32'h3F80_0000, 9);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
